// File: rtl/div_pkg.sv
// Shared types and constants for the leading-zero-skipping restoring divider.
package div_pkg;

  localparam int W        = 16;
  localparam int IDX_W    = 4;
  localparam int SKIP_MIN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } state_e;

  // The encoder reports 0 below its valid range, so low indices mean "unknown: do all W bits".
  function automatic logic [IDX_W:0] iter_count(input logic [IDX_W-1:0] msb_pos);
    if (msb_pos >= IDX_W'(SKIP_MIN))
      return {1'b0, msb_pos} + (IDX_W+1)'(1);
    else
      return (IDX_W+1)'(W);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step
  import div_pkg::*;
(
  input  logic [W-1:0] rem_in,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;

  // The restored remainder is always below the divisor, so W bits hold it between steps.
  always_comb begin
    shifted = {rem_in, din};
    if (shifted >= {1'b0, divisor}) begin
      rem_out = W'(shifted - {1'b0, divisor});
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted[W-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/lz_skip_divider.sv
// Iterative restoring divider that starts at the encoder-reported msb, skipping leading-zero steps.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   ITER  | one quotient bit per cycle, k counts down to 0
//   ZERO  | divisor was 0, load saturated result
//   DONE  | result held until out_ready
module lz_skip_divider
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     dividend,
  input  logic [W-1:0]     divisor,
  input  logic [IDX_W-1:0] msb_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     quotient,
  output logic [W-1:0]     remainder,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic [W-1:0]     dividend_q, dividend_d;
  logic [W-1:0]     divisor_q, divisor_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     q_q, q_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             div_zero_q, div_zero_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [W-1:0]     step_rem;
  logic             step_q;
  logic [IDX_W-1:0] k_start;

  div_step u_step (
    .rem_in  (rem_q),
    .din     (dividend_q[k_q]),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    q_d         = q_q;
    k_d         = k_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    k_start     = IDX_W'(iter_count(msb_pos) - (IDX_W+1)'(1));

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          rem_d      = '0;
          q_d        = '0;
          div_zero_d = 1'b0;
          k_d        = k_start;
          in_ready_d = 1'b0;
          state_d    = (divisor == '0) ? ZERO : ITER;
        end
      end
      ITER: begin
        rem_d      = step_rem;
        q_d[k_q]   = step_q;
        if (k_q == '0)
          state_d = DONE;
        else
          k_d = k_q - IDX_W'(1);
      end
      ZERO: begin
        q_d        = '1;
        rem_d      = dividend_q;
        div_zero_d = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        // out_valid is registered, so the first DONE cycle only raises it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      k_q         <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      k_q         <= k_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = q_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_lz_skip_divider.sv
// Self-checking bench: directed vector table, reset-abort sequence, then random ops vs. an arithmetic model.
module tb_lz_skip_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [3:0]  msb_pos;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  lz_skip_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .msb_pos   (msb_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [3:0]  msb;
    int          hold;
    logic [15:0] eq;
    logic [15:0] er;
    logic        edz;
    int          elat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Encoder model: index of the leading one, reported as 0 below 256.
  function automatic logic [3:0] enc(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++)
      if (v[i]) idx = 4'(i);
    if (v < 16'd256) idx = 4'd0;
    return idx;
  endfunction

  task automatic run_op(input logic [15:0] dvd, input logic [15:0] dvs, input logic [3:0] msb,
                        input int hold, input logic [15:0] eq, input logic [15:0] er,
                        input logic edz, input int elat, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready_pre"}, in_ready, 1);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    msb_pos  = msb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    msb_pos  = 4'($urandom);
    lat = 0;
    while (lat < 40) begin
      if (lat > 0 && out_valid) break;
      if (lat > 0) chk({tag, ".in_ready_busy"}, in_ready, 0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".quotient"}, quotient, eq);
    chk({tag, ".remainder"}, remainder, er);
    chk({tag, ".div_zero"}, div_zero, edz);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_in_ready"}, in_ready, 0);
      chk({tag, ".hold_q"}, quotient, eq);
      chk({tag, ".hold_r"}, remainder, er);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, out_valid, 0);
    chk({tag, ".in_ready_post"}, in_ready, 1);
  endtask

  initial begin
    logic [15:0] a, b;
    logic [3:0]  m;
    int          nn;

    vecs[0] = '{16'd1000,  16'd7,   4'd9,  0, 16'd142,  16'd6,    1'b0, 11};
    vecs[1] = '{16'hFFFF,  16'd1,   4'd15, 0, 16'hFFFF, 16'd0,    1'b0, 17};
    vecs[2] = '{16'd200,   16'd9,   4'd0,  0, 16'd22,   16'd2,    1'b0, 17};
    vecs[3] = '{16'd1234,  16'd0,   4'd0,  0, 16'hFFFF, 16'd1234, 1'b1, 2};
    vecs[4] = '{16'd50000, 16'd300, 4'd15, 5, 16'd166,  16'd200,  1'b0, 17};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    msb_pos   = '0;
    #12;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.quotient", quotient, 0);
    chk("rst.remainder", remainder, 0);
    chk("rst.div_zero", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].msb, vecs[i].hold,
             vecs[i].eq, vecs[i].er, vecs[i].edz, vecs[i].elat, $sformatf("vec%0d", i));

    // Reset asserted during the 4th ITER cycle aborts the divide.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'd50000;
    divisor  = 16'd300;
    msb_pos  = 4'd15;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", out_valid, 0);
    chk("abort.in_ready", in_ready, 1);
    chk("abort.quotient", quotient, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd100, 16'd10, 4'd0, 0, 16'd10, 16'd0, 1'b0, 17, "post_abort");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(0, 255));
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: b = 16'd0;
        1: b = 16'd1;
        2: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      m  = enc(a);
      nn = (m >= 4'd8) ? int'(m) + 1 : 16;
      if (b == 16'd0)
        run_op(a, b, m, int'($urandom_range(0, 3)), 16'hFFFF, a, 1'b1, 2, $sformatf("rnd%0d", i));
      else
        run_op(a, b, m, int'($urandom_range(0, 3)), a / b, a % b, 1'b0, nn + 1, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
